// File: rtl/muldiv_ctrl.sv
// HI/LO sequencing controller for the EX stage: registered multiply, restoring
// divide, MTHI/MTLO pass-through, one-cycle HI/LO write pulse and stall.
module muldiv_ctrl #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    output logic             stall_o,
    output logic             hilo_we_o,
    output logic [WIDTH-1:0] hi_wdata_o,
    output logic [WIDTH-1:0] lo_wdata_o
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam int unsigned   CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    logic [1:0]         state_q, state_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               qsign_q, qsign_d;
    logic               rsign_q, rsign_d;
    logic               we_q, we_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               accept;
    logic               is_signed_div;
    logic [2*WIDTH-1:0] smul, umul;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     rem_sh, trial;
    logic [WIDTH-1:0]   step_rem, step_quo;
    logic [WIDTH-1:0]   fin_quo, fin_rem;

    assign accept        = (state_q == S_IDLE) || (state_q == S_DONE);
    assign is_signed_div = (op_i == OP_DIV);

    assign smul = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i}) * $signed({{WIDTH{b_i[WIDTH-1]}}, b_i});
    assign umul = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

    assign a_abs = (is_signed_div && a_i[WIDTH-1]) ? ('0 - a_i) : a_i;
    assign b_abs = (is_signed_div && b_i[WIDTH-1]) ? ('0 - b_i) : b_i;

    // One restoring step: the dividend shifts out of quo_q while quotient bits shift in.
    assign rem_sh   = {rem_q, quo_q[WIDTH-1]};
    assign trial    = rem_sh - {1'b0, dvs_q};
    assign step_rem = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    assign step_quo = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
    assign fin_quo  = qsign_q ? ('0 - step_quo) : step_quo;
    assign fin_rem  = rsign_q ? ('0 - step_rem) : step_rem;

    always_comb begin
        stall_o = 1'b0;
        if (!flush_i) begin
            stall_o = (state_q == S_MUL) || (state_q == S_DIV) ||
                      (accept && (op_i == OP_MULT || op_i == OP_MULTU ||
                                  op_i == OP_DIV  || op_i == OP_DIVU));
        end
    end

    always_comb begin
        state_d = state_q;
        prod_d  = prod_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        we_d    = 1'b0;
        hi_d    = hi_q;
        lo_d    = lo_q;

        if (flush_i) begin
            state_d = S_IDLE;
        end else if (accept) begin
            state_d = S_IDLE;
            case (op_i)
                OP_MULT: begin
                    prod_d  = smul;
                    state_d = S_MUL;
                end
                OP_MULTU: begin
                    prod_d  = umul;
                    state_d = S_MUL;
                end
                OP_DIV, OP_DIVU: begin
                    if (b_i == '0) begin
                        state_d = S_DONE;
                        we_d    = 1'b1;
                        lo_d    = '1;
                        hi_d    = a_i;
                    end else begin
                        rem_d   = '0;
                        quo_d   = a_abs;
                        dvs_d   = b_abs;
                        cnt_d   = '0;
                        qsign_d = is_signed_div && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
                        rsign_d = is_signed_div && a_i[WIDTH-1];
                        state_d = S_DIV;
                    end
                end
                OP_MTHI: begin
                    we_d = 1'b1;
                    hi_d = a_i;
                    lo_d = lo_i;
                end
                OP_MTLO: begin
                    we_d = 1'b1;
                    hi_d = hi_i;
                    lo_d = a_i;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q == S_MUL) begin
            state_d = S_DONE;
            we_d    = 1'b1;
            hi_d    = prod_q[2*WIDTH-1:WIDTH];
            lo_d    = prod_q[WIDTH-1:0];
        end else begin
            rem_d = step_rem;
            quo_d = step_quo;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ITER) begin
                state_d = S_DONE;
                we_d    = 1'b1;
                hi_d    = fin_rem;
                lo_d    = fin_quo;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            prod_q  <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            we_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            prod_q  <= prod_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            we_q    <= we_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign hilo_we_o  = we_q;
    assign hi_wdata_o = hi_q;
    assign lo_wdata_o = lo_q;

endmodule
